ws_frame_sequencer: RTL and testbench

Parametrised frame sequencer for a WS2812-style LED chain: walks every pixel of a frame, strobes the downstream shift register for load and transmit, holds the line idle for a latch/frame gap, then advances the frame index. Sits between the frame-memory read port, which consumes `pixel_addr`/`frame`, and the serial bit shifter, which consumes `load_sreg`/`transmit_pixel`. Successor to the fixed 64-pixel controller: generalises geometry and timing, adds run/one-shot control, a busy/done handshake and optional serpentine addressing.

---
 rtl/ws_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_ws_frame_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ws_frame_sequencer.sv
// Frame sequencer for a WS2812-style LED chain: read, load, shift each pixel, then hold the latch gap.
// Optional build macro WS_SERPENTINE_EN reverses the address order of odd matrix rows.
module ws_frame_sequencer #(
  parameter int unsigned NUM_PIXELS     = 64,
  parameter int unsigned ROW_LEN        = 8,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned CYCLES_PER_BIT = 15,
  parameter int unsigned IDLE_CYCLES    = 1_576_832,
  parameter int unsigned NUM_FRAMES     = 32,
  localparam int unsigned PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  localparam int unsigned FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             load_sreg,
  output logic             transmit_pixel,
  output logic [PIX_W-1:0] pixel_index,
  output logic [PIX_W-1:0] pixel_addr,
  output logic [FRM_W-1:0] frame
);

  localparam int unsigned SHIFT_LEN = BITS_PER_PIXEL * CYCLES_PER_BIT;
  localparam int unsigned SH_W      = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
  localparam int unsigned GAP_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  typedef enum logic [2:0] {HALT, READ, LOAD, SHIFT, GAP} state_t;

  state_t             state;
  logic [SH_W-1:0]    shift_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PIX_W-1:0]   pix_nxt;
  logic [GAP_W-1:0]   gap_nxt;

  assign pix_nxt = pixel_index + PIX_W'(1);
  assign gap_nxt = gap_cnt + GAP_W'(1);

  // Maps a linear pixel index to its frame-memory address.
  function automatic logic [PIX_W-1:0] addr_of(input logic [PIX_W-1:0] idx);
`ifdef WS_SERPENTINE_EN
    int unsigned row;
    int unsigned col;
    row = 32'(idx) / ROW_LEN;
    col = 32'(idx) % ROW_LEN;
    if (row[0]) return PIX_W'(row * ROW_LEN + ROW_LEN - 1 - col);
    return idx;
`else
    return idx;
`endif
  endfunction

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HALT;
      shift_cnt      <= '0;
      gap_cnt        <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      load_sreg      <= 1'b0;
      transmit_pixel <= 1'b0;
      pixel_index    <= '0;
      pixel_addr     <= '0;
      frame          <= '0;
    end else begin
      case (state)
        HALT: begin
          if (run || start) begin
            state       <= READ;
            busy        <= 1'b1;
            pixel_index <= '0;
            pixel_addr  <= '0;
          end
        end
        READ: begin
          state     <= LOAD;
          load_sreg <= 1'b1;
        end
        LOAD: begin
          state          <= SHIFT;
          load_sreg      <= 1'b0;
          transmit_pixel <= 1'b1;
          shift_cnt      <= '0;
        end
        SHIFT: begin
          if (shift_cnt == SH_W'(SHIFT_LEN - 1)) begin
            transmit_pixel <= 1'b0;
            if (pixel_index == PIX_W'(NUM_PIXELS - 1)) begin
              state       <= GAP;
              pixel_index <= '0;
              pixel_addr  <= '0;
              gap_cnt     <= '0;
              frame_done  <= (IDLE_CYCLES == 1);
            end else begin
              state       <= READ;
              pixel_index <= pix_nxt;
              pixel_addr  <= addr_of(pix_nxt);
            end
          end else begin
            shift_cnt <= shift_cnt + SH_W'(1);
          end
        end
        GAP: begin
          // frame_done is raised one edge early so it coincides with the final gap cycle.
          if (gap_cnt == GAP_W'(IDLE_CYCLES - 1)) begin
            frame_done <= 1'b0;
            frame      <= (frame == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame + FRM_W'(1);
            state      <= run ? READ : HALT;
            busy       <= run;
          end else begin
            gap_cnt    <= gap_nxt;
            frame_done <= (gap_nxt == GAP_W'(IDLE_CYCLES - 1));
          end
        end
        default: begin
          state <= HALT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Scoreboard bench for ws_frame_sequencer with a small 16-pixel, 8-wide geometry.
module tb_ws_frame_sequencer;

  localparam int NP    = 16;
  localparam int RL    = 8;
  localparam int BPP   = 2;
  localparam int CPB   = 3;
  localparam int IDLE  = 5;
  localparam int NF    = 3;
  localparam int PW    = 4;
  localparam int FW    = 2;
  localparam int T     = BPP * CPB;
  localparam int PPER  = T + 2;
  localparam int FPER  = NP * PPER + IDLE;

  typedef struct {
    bit is_done;
    int cyc;
    int idx;
    int addr;
    int frm;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          load_sreg;
  logic          transmit_pixel;
  logic [PW-1:0] pixel_index;
  logic [PW-1:0] pixel_addr;
  logic [FW-1:0] frame;

  ws_frame_sequencer #(
    .NUM_PIXELS(NP), .ROW_LEN(RL), .BITS_PER_PIXEL(BPP),
    .CYCLES_PER_BIT(CPB), .IDLE_CYCLES(IDLE), .NUM_FRAMES(NF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .start(start),
    .busy(busy), .frame_done(frame_done), .load_sreg(load_sreg),
    .transmit_pixel(transmit_pixel), .pixel_index(pixel_index),
    .pixel_addr(pixel_addr), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   tx_cnt = 0;
  int   overlap = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   addr_tab [NP];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events for one frame whose pixel 0 READ starts after edge r.
  task automatic push_frame(input int r, input int f);
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.is_done = 1'b0;
      e.cyc     = r + 1 + PPER * p;
      e.idx     = p;
      e.addr    = addr_tab[p];
      e.frm     = f;
      sb.push_back(e);
    end
    e.is_done = 1'b1;
    e.cyc     = r + FPER - 1;
    e.idx     = 0;
    e.addr    = 0;
    e.frm     = f;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_remaining", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: pops an expectation whenever the DUT strobes load or frame_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_sreg && transmit_pixel) overlap++;
      if (transmit_pixel) tx_cnt++;
      if (load_sreg || frame_done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_event: load=%0b done=%0b at cycle %0d, expected none",
                   load_sreg, frame_done, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", int'(frame_done), int'(mon_e.is_done));
          check("event_cycle", cyc, mon_e.cyc);
          check("busy_active", int'(busy), 1);
          check("frame", int'(frame), mon_e.frm);
          if (!mon_e.is_done) begin
            check("pixel_index", int'(pixel_index), mon_e.idx);
            check("pixel_addr", int'(pixel_addr), mon_e.addr);
          end else begin
            check("tx_cycles", tx_cnt, NP * T);
            check("load_tx_overlap", overlap, 0);
            tx_cnt  = 0;
            overlap = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    int nz;
`ifdef WS_SERPENTINE_EN
    addr_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 15, 14, 13, 12, 11, 10, 9, 8};
`else
    addr_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    rst_n = 1'b0;
    run   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_load", int'(load_sreg), 0);
    check("rst_tx", int'(transmit_pixel), 0);
    check("rst_frame", int'(frame), 0);

    // Idle after reset: nothing may move.
    rst_n = 1'b1;
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || frame_done || load_sreg || transmit_pixel ||
          pixel_index != '0 || pixel_addr != '0 || frame != '0) nz++;
    end
    check("idle_quiet", nz, 0);

    // One-shot frame.
    start = 1'b1;
    push_frame(cyc + 1, 0);
    @(negedge clk);
    start = 1'b0;
    wait_drain(FPER + 20);
    repeat (5) @(negedge clk);
    check("oneshot_busy", int'(busy), 0);
    check("oneshot_frame", int'(frame), 1);

    // Continuous run: back-to-back frames 1,2,0,1; run drops in pixel 2 of the last.
    run = 1'b1;
    r0  = cyc + 1;
    for (int f = 0; f < 4; f++) push_frame(r0 + FPER * f, (1 + f) % NF);
    while (cyc < r0 + 3 * FPER + 1 + 2 * PPER + 3) @(negedge clk);
    check("midframe_tx", int'(transmit_pixel), 1);
    run   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(4 * FPER + 20);
    repeat (20) @(negedge clk);
    check("run_drop_busy", int'(busy), 0);
    check("run_drop_frame", int'(frame), 2);

    // Async reset during SHIFT, then restart with run held.
    run = 1'b1;
    r0  = cyc + 1;
    push_frame(r0, 2);
    while (cyc < r0 + 1 + PPER + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_tx", int'(transmit_pixel), 0);
    check("arst_load", int'(load_sreg), 0);
    check("arst_index", int'(pixel_index), 0);
    check("arst_addr", int'(pixel_addr), 0);
    check("arst_frame", int'(frame), 0);
    sb.delete();
    tx_cnt  = 0;
    overlap = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(cyc + 1, 0);
    repeat (4) @(negedge clk);
    run = 1'b0;
    wait_drain(FPER + 20);
    repeat (5) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_frame", int'(frame), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
